// File: rtl/operand_fetch.sv
// operand_fetch: ID->EX operand stage. Reads the register file, bypasses
// EX/WB results, detects load-use hazards and registers the EX bundle.
// Ports: clk, rst (sync, active-high); id_* decoded instruction in;
//   rf_adr1/2 out, rf_data1/2 in; alu_result, wb_we/wb_rd/wb_data bypass;
//   flush in, stall out; of_* registered EX bundle, stall_count (sat. 8b).
module operand_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_op,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic [3:0] id_rd,
  input  logic [7:0] id_imm,
  input  logic       id_use_imm,
  input  logic       id_reg_write,
  input  logic       id_is_load,
  output logic [3:0] rf_adr1,
  output logic [3:0] rf_adr2,
  input  logic [7:0] rf_data1,
  input  logic [7:0] rf_data2,
  input  logic [7:0] alu_result,
  input  logic       wb_we,
  input  logic [3:0] wb_rd,
  input  logic [7:0] wb_data,
  input  logic       flush,
  output logic       stall,
  output logic       of_valid,
  output logic [3:0] of_op,
  output logic [7:0] of_a,
  output logic [7:0] of_b,
  output logic [3:0] of_rd,
  output logic       of_reg_write,
  output logic       of_is_load,
  output logic [7:0] stall_count
);

  logic       valid_q, valid_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] rd_q, rd_d;
  logic       rw_q, rw_d;
  logic       ld_q, ld_d;
  logic [7:0] cnt_q, cnt_d;

  logic       ex_fwd;
  logic       a_ex, a_wb;
  logic       b_ex, b_wb;
  logic [7:0] opa, opb;
  logic       hit1, hit2;

  assign rf_adr1 = id_rs1;
  assign rf_adr2 = id_rs2;

  // Loads have no result in EX yet; they are covered by the stall.
  assign ex_fwd = valid_q & rw_q & ~ld_q;

  assign a_ex = ex_fwd & (rd_q == id_rs1);
  assign a_wb = wb_we & (wb_rd == id_rs1);
  assign b_ex = ex_fwd & (rd_q == id_rs2);
  assign b_wb = wb_we & (wb_rd == id_rs2);

  always_comb begin
    opa = rf_data1;
    if (id_rs1 == 4'd0) opa = 8'h00;
    else if (a_ex)      opa = alu_result;
    else if (a_wb)      opa = wb_data;
  end

  always_comb begin
    opb = rf_data2;
    if (id_use_imm)          opb = id_imm;
    else if (id_rs2 == 4'd0) opb = 8'h00;
    else if (b_ex)           opb = alu_result;
    else if (b_wb)           opb = wb_data;
  end

  assign hit1 = (rd_q == id_rs1);
  assign hit2 = (rd_q == id_rs2) & ~id_use_imm;

  assign stall = ~rst & id_valid & ~flush
               & valid_q & ld_q & rw_q
               & (rd_q != 4'd0)
               & (hit1 | hit2);

  always_comb begin
    valid_d = id_valid;
    op_d    = id_op;
    a_d     = opa;
    b_d     = opb;
    rd_d    = id_rd;
    rw_d    = id_reg_write & id_valid;
    ld_d    = id_is_load & id_valid;
    cnt_d   = cnt_q;
    if (flush | stall) begin
      // Bubble: kill control bits, keep the datapath fields.
      valid_d = 1'b0;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      rw_d    = 1'b0;
      ld_d    = 1'b0;
    end
    if (stall && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ld_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign of_valid     = valid_q;
  assign of_op        = op_q;
  assign of_a         = a_q;
  assign of_b         = b_q;
  assign of_rd        = rd_q;
  assign of_reg_write = rw_q;
  assign of_is_load   = ld_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus random traffic against a
// behavioural model of the operand stage.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_op, id_rs1, id_rs2, id_rd;
  logic [7:0] id_imm;
  logic       id_use_imm, id_reg_write, id_is_load;
  logic [3:0] rf_adr1, rf_adr2;
  logic [7:0] rf_data1, rf_data2;
  logic [7:0] alu_result;
  logic       wb_we;
  logic [3:0] wb_rd;
  logic [7:0] wb_data;
  logic       flush;
  logic       stall;
  logic       of_valid;
  logic [3:0] of_op;
  logic [7:0] of_a, of_b;
  logic [3:0] of_rd;
  logic       of_reg_write, of_is_load;
  logic [7:0] stall_count;

  logic [7:0] rf [16];
  int total = 0;
  int bad = 0;

  assign rf_data1 = rf[rf_adr1];
  assign rf_data2 = rf[rf_adr2];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .rf_adr1(rf_adr1), .rf_adr2(rf_adr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .alu_result(alu_result),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall),
    .of_valid(of_valid), .of_op(of_op),
    .of_a(of_a), .of_b(of_b), .of_rd(of_rd),
    .of_reg_write(of_reg_write), .of_is_load(of_is_load),
    .stall_count(stall_count)
  );

  typedef struct {
    bit       v;
    bit [3:0] op;
    bit [7:0] a;
    bit [7:0] b;
    bit [3:0] rd;
    bit       rw;
    bit       ld;
  } ex_t;

  ex_t m  = '{0, 0, 0, 0, 0, 0, 0};
  ex_t mn = '{0, 0, 0, 0, 0, 0, 0};
  int  mcnt = 0;
  int  mcnt_n = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Value register r holds from ID's point of view: youngest producer wins.
  function automatic bit [7:0] src(bit [3:0] r);
    if (r == 0) return 8'h00;
    if (m.v && m.rw && !m.ld && m.rd == r) return alu_result;
    if (wb_we && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  always @(negedge clk) begin
    bit hz, es;
    hz = m.v && m.ld && m.rw && m.rd != 0 &&
         (m.rd == id_rs1 || (m.rd == id_rs2 && !id_use_imm));
    es = !rst && id_valid && !flush && hz;
    chk("stall", int'(stall), int'(es));
    chk("rf_adr1", int'(rf_adr1), int'(id_rs1));
    chk("rf_adr2", int'(rf_adr2), int'(id_rs2));
    chk("of_valid", int'(of_valid), int'(m.v));
    chk("of_op", int'(of_op), int'(m.op));
    chk("of_a", int'(of_a), int'(m.a));
    chk("of_b", int'(of_b), int'(m.b));
    chk("of_rd", int'(of_rd), int'(m.rd));
    chk("of_reg_write", int'(of_reg_write), int'(m.rw));
    chk("of_is_load", int'(of_is_load), int'(m.ld));
    chk("stall_count", int'(stall_count), mcnt);
    mcnt_n = mcnt;
    if (rst) begin
      mn = '{0, 0, 0, 0, 0, 0, 0};
      mcnt_n = 0;
    end else if (flush || es) begin
      mn = m;
      mn.v = 0;
      mn.rw = 0;
      mn.ld = 0;
      if (es && mcnt < 255) mcnt_n = mcnt + 1;
    end else begin
      mn.v  = id_valid;
      mn.op = id_op;
      mn.rd = id_rd;
      mn.a  = src(id_rs1);
      mn.b  = id_use_imm ? id_imm : src(id_rs2);
      mn.rw = id_reg_write && id_valid;
      mn.ld = id_is_load && id_valid;
    end
  end

  always @(posedge clk) begin
    m <= mn;
    mcnt <= mcnt_n;
    if (wb_we) rf[wb_rd] <= wb_data;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    id_valid = 0; id_op = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_imm = 0; id_use_imm = 0; id_reg_write = 0; id_is_load = 0;
    alu_result = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic put(bit [3:0] op, bit [3:0] rs1, bit [3:0] rs2,
                     bit [3:0] rd, bit rw, bit ld);
    id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  initial begin
    int sc;
    for (int i = 0; i < 16; i++) rf[i] = 8'(i * 16 + i);
    idle();
    rst = 1;
    cyc();
    cyc();
    chk("rst of_valid", int'(of_valid), 0);
    chk("rst count", int'(stall_count), 0);
    rst = 0;

    // WB bypass
    rf[3] = 8'h11;
    put(4'd1, 4'd3, 4'd0, 4'd6, 1, 0);
    wb_we = 1; wb_rd = 3; wb_data = 8'h5A;
    cyc();
    chk("wb byp of_a", int'(of_a), 8'h5A);
    chk("wb byp of_valid", int'(of_valid), 1);

    // EX bypass beats WB
    put(4'd2, 4'd0, 4'd0, 4'd4, 1, 0);
    wb_we = 0;
    cyc();
    put(4'd3, 4'd0, 4'd4, 4'd7, 1, 0);
    alu_result = 8'h22;
    wb_we = 1; wb_rd = 4; wb_data = 8'h33;
    cyc();
    chk("ex byp of_b", int'(of_b), 8'h22);

    // load-use stall then WB forwarding
    wb_we = 0; alu_result = 0;
    put(4'd4, 4'd0, 4'd0, 4'd5, 1, 1);
    cyc();
    put(4'd5, 4'd5, 4'd0, 4'd7, 1, 0);
    #1;
    chk("lu stall", int'(stall), 1);
    cyc();
    chk("lu bubble", int'(of_valid), 0);
    chk("lu count", int'(stall_count), 1);
    wb_we = 1; wb_rd = 5; wb_data = 8'h7E;
    #1;
    chk("lu replay no stall", int'(stall), 0);
    cyc();
    chk("lu of_a", int'(of_a), 8'h7E);
    chk("lu of_valid", int'(of_valid), 1);

    // immediate and r0
    wb_we = 0;
    put(4'd4, 4'd0, 4'd0, 4'd5, 1, 1);
    cyc();
    put(4'd6, 4'd0, 4'd5, 4'd8, 1, 0);
    id_use_imm = 1; id_imm = 8'h80;
    wb_we = 1; wb_rd = 0; wb_data = 8'hFF;
    #1;
    chk("imm no stall", int'(stall), 0);
    cyc();
    chk("imm of_b", int'(of_b), 8'h80);
    chk("r0 of_a", int'(of_a), 8'h00);

    // flush during load-use
    wb_we = 0; id_use_imm = 0;
    put(4'd4, 4'd0, 4'd0, 4'd5, 1, 1);
    cyc();
    sc = int'(stall_count);
    put(4'd5, 4'd5, 4'd0, 4'd7, 1, 0);
    flush = 1;
    #1;
    chk("flush stall", int'(stall), 0);
    cyc();
    flush = 0;
    chk("flush bubble", int'(of_valid), 0);
    chk("flush count", int'(stall_count), sc);

    // saturation: 300 load/use pairs
    for (int i = 0; i < 300; i++) begin
      id_use_imm = 1;
      put(4'd4, 4'd0, 4'd0, 4'd5, 1, 1);
      cyc();
      id_use_imm = 0;
      put(4'd5, 4'd5, 4'd0, 4'd7, 1, 0);
      cyc();
    end
    chk("sat count", int'(stall_count), 255);
    put(4'd4, 4'd0, 4'd0, 4'd5, 1, 1);
    cyc();
    put(4'd5, 4'd5, 4'd0, 4'd7, 1, 0);
    rst = 1;
    #1;
    chk("rst stall", int'(stall), 0);
    cyc();
    rst = 0;
    chk("rst2 of_valid", int'(of_valid), 0);
    chk("rst2 of_a", int'(of_a), 0);
    chk("rst2 of_b", int'(of_b), 0);
    chk("rst2 of_rd", int'(of_rd), 0);
    chk("rst2 of_op", int'(of_op), 0);
    chk("rst2 of_is_load", int'(of_is_load), 0);
    chk("rst2 count", int'(stall_count), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_op        = 4'($urandom);
      id_rs1       = 4'($urandom_range(0, 7));
      id_rs2       = 4'($urandom_range(0, 7));
      id_rd        = 4'($urandom_range(0, 7));
      id_imm       = 8'($urandom);
      id_use_imm   = ($urandom_range(0, 3) == 0);
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_is_load   = ($urandom_range(0, 2) == 0);
      alu_result   = 8'($urandom);
      wb_we        = $urandom_range(0, 1) == 1;
      wb_rd        = 4'($urandom_range(0, 7));
      wb_data      = 8'($urandom);
      cyc();
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
